// File: rtl/mult_control.sv
// Sequencing FSM for the 8-bit signed shift-add multiplier: eight add/shift
// iterations, final partial product subtracted. Optional macro MULT_CTRL_SKIP_ZERO_EN.
module mult_control (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clra_ldb,
  input  logic m,
  output logic shift,
  output logic sub_add,
  output logic Ld_XA,
  output logic Ld_B,
  output logic Clr_XA,
  output logic busy,
  output logic done
);

  typedef enum logic [2:0] {IDLE, CLR, ADD, SHIFT, DONE} state_t;

  state_t     st_q, st_d;
  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    shift   = 1'b0;
    sub_add = 1'b1;
    Ld_XA   = 1'b0;
    Ld_B    = 1'b0;
    Clr_XA  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (st_q)
      IDLE: begin
        Ld_B   = clra_ldb & ~run;
        Clr_XA = clra_ldb & ~run;
        if (run) begin
          st_d  = CLR;
          cnt_d = '0;
        end
      end
      CLR: begin
        Clr_XA = 1'b1;
        busy   = 1'b1;
        st_d   = ADD;
      end
      ADD: begin
        busy    = 1'b1;
        Ld_XA   = m;
        sub_add = (cnt_q != 3'd7);
        st_d    = SHIFT;
`ifdef MULT_CTRL_SKIP_ZERO_EN
        // A zero multiplier bit needs no add, so shift in the same cycle.
        if (!m) begin
          shift = 1'b1;
          if (cnt_q == 3'd7) begin
            st_d = DONE;
          end else begin
            cnt_d = cnt_q + 3'd1;
            st_d  = ADD;
          end
        end
`endif
      end
      SHIFT: begin
        busy  = 1'b1;
        shift = 1'b1;
        if (cnt_q == 3'd7) begin
          st_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
          st_d  = ADD;
        end
      end
      DONE: begin
        done = 1'b1;
        if (!run) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
    // Reset overrides the IDLE defaults, including sub_add.
    if (!reset) begin
      shift   = 1'b0;
      sub_add = 1'b0;
      Ld_XA   = 1'b0;
      Ld_B    = 1'b0;
      Clr_XA  = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= IDLE;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: doc/mult_control.md
# mult_control

Sequencing FSM for the 8-bit signed shift-add multiplier datapath. It sits directly upstream of the add/subtract stage and the X/A/B register unit. It drives their load, clear, shift and add/subtract-select controls so that eight add-then-shift iterations run per multiplication, with the final partial product subtracted (two's-complement sign bit of the multiplier). It samples only the multiplier LSB `m` from the datapath.

## Interface
Parameters: none.

- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset; one clock domain
- `run`  in  1  level request to start a multiplication
- `clra_ldb`  in  1  level request, honoured in IDLE only: clear X/A and load B from switches
- `m`  in  1  current multiplier LSB (B[0]) from the register unit
- `shift`  out  1  shift X:A:B right one bit this cycle
- `sub_add`  out  1  1 = add S to A, 0 = subtract S from A
- `Ld_XA`  out  1  load adder/subtractor result into X and A this cycle
- `Ld_B`  out  1  load B register
- `Clr_XA`  out  1  clear X and A
- `busy`  out  1  multiplication in progress
- `done`  out  1  result valid in A:B; held until `run` released

## Operation
- State: `st` ∈ {IDLE, CLR, ADD, SHIFT, DONE}; 3-bit iteration counter `cnt`.
- IDLE:
  - `Ld_B = Clr_XA = clra_ldb & ~run`.
  - If `run`=1, go to CLR and set `cnt`=0. `run` has priority over `clra_ldb`.
- CLR: `Clr_XA`=1. Next state is ADD.
- ADD:
  - `Ld_XA = m`.
  - `sub_add = (cnt != 7)`, so bits 0–6 add and bit 7 subtracts.
  - Next state is SHIFT.
- SHIFT:
  - `shift`=1.
  - If `cnt`==7, go to DONE; otherwise increment `cnt` and go to ADD.
- DONE:
  - `done`=1.
  - Stay while `run`=1; go to IDLE when `run`=0.
  - A run level held high never starts a second multiplication.
- `busy` = 1 in CLR, ADD and SHIFT.
- Default values: `sub_add`=1 outside ADD; every other output 0 unless asserted above.
- Outputs are combinational from `st`, `cnt`, `m`, `run` and `clra_ldb`. `m` may change every cycle and is trusted only in ADD.
- `cnt` wraps never occur: `cnt` is reset to 0 on IDLE→CLR and is never incremented past 7.

## Timing
- While `reset`=0:
  - State is IDLE and `cnt`=0.
  - Every output is forced to 0, including `sub_add` and regardless of `clra_ldb`.
- After `reset` releases, IDLE defaults apply from the next evaluation.
- Latency without the macro:
  - `run` is sampled high at edge 0.
  - CLR occupies cycle 1.
  - ADD/SHIFT for bit i occupy cycles 2+2i and 3+2i.
  - DONE is entered at cycle 18, giving 17 busy cycles independent of data.
- `Ld_XA` and `shift` are never asserted in the same cycle (without the macro).
- Reset mid-operation aborts immediately to IDLE with all outputs 0. If `run` is still high when reset releases, a fresh multiplication starts: CLR follows one cycle later.
- Changes on `clra_ldb` during CLR, ADD, SHIFT or DONE are ignored.

## Configuration
- Macro: `MULT_CTRL_SKIP_ZERO_EN`.
- Undefined: behaviour exactly as above, fixed 17-cycle operation.
- Defined, ADD behaviour when `m`=0:
  - Assert `shift`=1 and `Ld_XA`=0, with `sub_add` per the normal rule.
  - Skip SHIFT: if `cnt`==7 go to DONE, else increment `cnt` and stay in ADD.
- Defined, ADD behaviour when `m`=1: unchanged.
- Busy cycles become 1 + 8 + popcount(B), where B is the multiplier value (minimum 9, maximum 17).

## Test plan
- Reset held low with `run`=1 and `clra_ldb`=1 → all outputs 0, including `sub_add`. Release reset with `run` low → IDLE, `sub_add`=1, other outputs 0.
- IDLE with `clra_ldb`=1 and `run`=0 → `Ld_B`=`Clr_XA`=1 in the same cycle. Raise `run` too → both drop to 0 combinationally.
- `m` held 1, pulse `run` high and keep it high →
  - `Clr_XA` at cycle 1.
  - `Ld_XA` at cycles 2,4,…,16, with `sub_add`=1 except cycle 16 (`sub_add`=0).
  - `shift` at cycles 3,5,…,17.
  - `done` from cycle 18 until `run` drops, then IDLE next cycle.
- `m` held 0 → `Ld_XA` never asserted, 8 shifts, `done` at cycle 18. With `MULT_CTRL_SKIP_ZERO_EN`: shifts at cycles 2–9, `done` at cycle 10.
- `m` follows B=0x07 (1,1,1,0,0,0,0,0) → `Ld_XA` asserted only in the ADD cycles for bits 0–2. With the macro, `done` at cycle 13.
- Assert `reset` at cycle 7 with `run` still high, release at cycle 9 → outputs 0 during reset, IDLE, then CLR on the next cycle. The full sequence restarts with `cnt`=0.
